// File: rtl/liveness_watchdog_mon.sv
// rtl/liveness_watchdog_mon.sv - multi-channel req/ack starvation and ack-stuck monitor with sticky flags
// Optional per-channel max completion latency output enabled by LIVE_MON_MAXLAT_EN.
module liveness_watchdog_mon #(
  parameter int N_CH         = 4,
  parameter int CNT_W        = 8,
  parameter int ACK_HOLD_MAX = 20,
  localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] timeout,
  input  logic             clr_err,
  input  logic [N_CH-1:0]  req,
  input  logic [N_CH-1:0]  ack,
  output logic [N_CH-1:0]  err_starve,
  output logic [N_CH-1:0]  err_stuck,
  output logic             err_any,
  output logic             first_valid,
  output logic [CH_W-1:0]  first_ch
`ifdef LIVE_MON_MAXLAT_EN
  ,
  output logic [N_CH*CNT_W-1:0] max_lat
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_VIOL} state_e;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(ACK_HOLD_MAX - 1);

  state_e           state_q [N_CH];
  state_e           state_d [N_CH];
  logic [CNT_W-1:0] pend_q  [N_CH];
  logic [CNT_W-1:0] pend_d  [N_CH];
  logic [CNT_W-1:0] hold_q  [N_CH];
  logic [CNT_W-1:0] hold_d  [N_CH];
  logic [N_CH-1:0]  new_starve, new_stuck, new_any;
  logic [N_CH-1:0]  starve_q, starve_d, stuck_q, stuck_d;
  logic             fvalid_q, fvalid_d;
  logic [CH_W-1:0]  fch_q, fch_d;
`ifdef LIVE_MON_MAXLAT_EN
  logic [N_CH-1:0]  complete;
  logic [CNT_W-1:0] lat_q [N_CH];
  logic [CNT_W-1:0] lat_d [N_CH];
`endif

  always_comb begin
    new_starve = '0;
    new_stuck  = '0;
`ifdef LIVE_MON_MAXLAT_EN
    complete   = '0;
`endif
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      pend_d[i]  = pend_q[i];
      hold_d[i]  = hold_q[i];
      if (!enable) begin
        state_d[i] = S_IDLE;
        pend_d[i]  = '0;
        hold_d[i]  = '0;
      end else begin
        case (state_q[i])
          S_IDLE: begin
            if (req[i] && !ack[i]) begin
              state_d[i] = S_WAIT;
              pend_d[i]  = CNT_ONE;
            end
          end
          S_WAIT: begin
            if (ack[i] || !req[i]) begin
              state_d[i] = S_IDLE;
              pend_d[i]  = '0;
`ifdef LIVE_MON_MAXLAT_EN
              complete[i] = ack[i];
`endif
            end else begin
              pend_d[i] = (&pend_q[i]) ? pend_q[i] : pend_q[i] + CNT_ONE;
              // >= rather than == so a timeout lowered below pend still fires
              if ((timeout != '0) &&
                  (({1'b0, pend_q[i]} + {{CNT_W{1'b0}}, 1'b1}) >= {1'b0, timeout})) begin
                new_starve[i] = 1'b1;
                state_d[i]    = S_VIOL;
              end
            end
          end
          S_VIOL: begin
            if (ack[i] || !req[i]) begin
              state_d[i] = S_IDLE;
              pend_d[i]  = '0;
            end
          end
          default: begin
            state_d[i] = S_IDLE;
            pend_d[i]  = '0;
          end
        endcase
        if (ack[i]) begin
          hold_d[i]    = (&hold_q[i]) ? hold_q[i] : hold_q[i] + CNT_ONE;
          new_stuck[i] = (hold_q[i] == HOLD_LAST);
        end else begin
          hold_d[i] = '0;
        end
      end
    end
  end

  // A violation on the same edge as clr_err survives the clear and re-captures.
  always_comb begin
    new_any  = new_starve | new_stuck;
    starve_d = (clr_err ? '0 : starve_q) | new_starve;
    stuck_d  = (clr_err ? '0 : stuck_q) | new_stuck;
    fvalid_d = fvalid_q;
    fch_d    = fch_q;
    if ((new_any != '0) && (!fvalid_q || clr_err)) begin
      fvalid_d = 1'b1;
      for (int i = N_CH - 1; i >= 0; i--) begin
        if (new_any[i]) fch_d = CH_W'(i);
      end
    end else if (clr_err) begin
      fvalid_d = 1'b0;
    end
  end

`ifdef LIVE_MON_MAXLAT_EN
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      lat_d[i] = clr_err ? '0 : lat_q[i];
      if (complete[i] && (pend_q[i] > lat_d[i])) lat_d[i] = pend_q[i];
      max_lat[i*CNT_W +: CNT_W] = lat_q[i];
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= S_IDLE;
        pend_q[i]  <= '0;
        hold_q[i]  <= '0;
`ifdef LIVE_MON_MAXLAT_EN
        lat_q[i]   <= '0;
`endif
      end
      starve_q <= '0;
      stuck_q  <= '0;
      fvalid_q <= 1'b0;
      fch_q    <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        pend_q[i]  <= pend_d[i];
        hold_q[i]  <= hold_d[i];
`ifdef LIVE_MON_MAXLAT_EN
        lat_q[i]   <= lat_d[i];
`endif
      end
      starve_q <= starve_d;
      stuck_q  <= stuck_d;
      fvalid_q <= fvalid_d;
      fch_q    <= fch_d;
    end
  end

  assign err_starve  = starve_q;
  assign err_stuck   = stuck_q;
  assign err_any     = |{starve_q, stuck_q};
  assign first_valid = fvalid_q;
  assign first_ch    = fch_q;

endmodule

// File: tb/tb_liveness_watchdog_mon.sv
// tb/tb_liveness_watchdog_mon.sv - table, directed and randomized checks of liveness_watchdog_mon
module tb_liveness_watchdog_mon;

  localparam int NC   = 4;
  localparam int HOLD = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] timeout = '0;
  logic       clr_err = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] ack = '0;
  logic [3:0] err_starve, err_stuck;
  logic       err_any, first_valid;
  logic [1:0] first_ch;
`ifdef LIVE_MON_MAXLAT_EN
  logic [31:0] max_lat;
`endif

  liveness_watchdog_mon dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .timeout(timeout), .clr_err(clr_err),
    .req(req), .ack(ack), .err_starve(err_starve), .err_stuck(err_stuck),
    .err_any(err_any), .first_valid(first_valid), .first_ch(first_ch)
`ifdef LIVE_MON_MAXLAT_EN
    , .max_lat(max_lat)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference: run lengths of pending / ack-high cycles per channel
  int       run [NC];
  bit       flg [NC];
  int       arun[NC];
  int       mlat[NC];
  bit [3:0] m_starve, m_stuck;
  bit       m_fv;
  int       m_fch;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      run[i] = 0; flg[i] = 0; arun[i] = 0; mlat[i] = 0;
    end
    m_starve = '0; m_stuck = '0; m_fv = 0; m_fch = 0;
  endtask

  task automatic model_edge();
    bit [3:0] ns, nk, nany;
    int lat;
    ns = '0; nk = '0;
    if (clr_err) for (int i = 0; i < NC; i++) mlat[i] = 0;
    for (int i = 0; i < NC; i++) begin
      if (!enable) begin
        run[i] = 0; flg[i] = 0; arun[i] = 0;
      end else begin
        if (req[i] && !ack[i]) begin
          run[i]++;
          if (run[i] >= 2 && !flg[i] && timeout != 0 && run[i] >= int'(timeout)) begin
            ns[i] = 1; flg[i] = 1;
          end
        end else begin
          if (ack[i] && run[i] >= 1 && !flg[i]) begin
            lat = (run[i] > 255) ? 255 : run[i];
            if (lat > mlat[i]) mlat[i] = lat;
          end
          run[i] = 0; flg[i] = 0;
        end
        if (ack[i]) begin
          arun[i]++;
          if (arun[i] == HOLD) nk[i] = 1;
        end else arun[i] = 0;
      end
    end
    nany = ns | nk;
    if (nany != 0 && (!m_fv || clr_err)) begin
      m_fv = 1;
      for (int i = NC - 1; i >= 0; i--) if (nany[i]) m_fch = i;
    end else if (clr_err) m_fv = 0;
    if (clr_err) begin m_starve = '0; m_stuck = '0; end
    m_starve |= ns;
    m_stuck  |= nk;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic cmp_model();
    check("starve", 32'(err_starve), 32'(m_starve));
    check("stuck", 32'(err_stuck), 32'(m_stuck));
    check("err_any", 32'(err_any), 32'(|{m_starve, m_stuck}));
    check("first_valid", 32'(first_valid), 32'(m_fv));
    if (m_fv) check("first_ch", 32'(first_ch), 32'(m_fch));
`ifdef LIVE_MON_MAXLAT_EN
    for (int i = 0; i < NC; i++) check("max_lat", 32'(max_lat[i*8 +: 8]), 32'(mlat[i]));
`endif
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      cmp_model();
    end
  endtask

  typedef struct {
    logic       en; logic clr; logic [7:0] to; logic [3:0] rq; logic [3:0] ak;
    logic [3:0] e_starve; logic [3:0] e_stuck; logic e_fv; logic [1:0] e_fch;
  } vec_t;

  vec_t vt[17];

  initial begin
    vt[0]  = '{1, 0, 4, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 0};
    vt[1]  = '{1, 0, 4, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 0};
    vt[2]  = '{1, 0, 4, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 0};
    vt[3]  = '{1, 0, 4, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 1, 0};
    vt[4]  = '{1, 1, 4, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0};
    vt[5]  = '{1, 0, 4, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 0};
    vt[6]  = '{1, 0, 4, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 0};
    vt[7]  = '{1, 0, 4, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 0};
    vt[8]  = '{1, 0, 4, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 0, 0};
    vt[9]  = '{1, 0, 4, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0};
    vt[10] = '{1, 0, 4, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 0, 0};
    vt[11] = '{1, 0, 4, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 0, 0};
    vt[12] = '{1, 0, 4, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 0, 0};
    vt[13] = '{1, 0, 4, 4'b1010, 4'b0000, 4'b1010, 4'b0000, 1, 1};
    vt[14] = '{1, 0, 4, 4'b0000, 4'b0000, 4'b1010, 4'b0000, 1, 1};
    vt[15] = '{1, 1, 4, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0};
    vt[16] = '{1, 0, 4, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0};

    model_reset();
    #12;
    check("rst_starve", 32'(err_starve), 32'h0);
    check("rst_stuck", 32'(err_stuck), 32'h0);
    check("rst_any", 32'(err_any), 32'h0);
    check("rst_fv", 32'(first_valid), 32'h0);
    check("rst_fch", 32'(first_ch), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // table: single starve, ack just in time, dual starve with clear
    for (int v = 0; v < 17; v++) begin
      enable = vt[v].en; clr_err = vt[v].clr; timeout = vt[v].to;
      req = vt[v].rq; ack = vt[v].ak;
      tick();
      check("tbl_starve", 32'(err_starve), 32'(vt[v].e_starve));
      check("tbl_stuck", 32'(err_stuck), 32'(vt[v].e_stuck));
      check("tbl_any", 32'(err_any), 32'(|{vt[v].e_starve, vt[v].e_stuck}));
      check("tbl_fv", 32'(first_valid), 32'(vt[v].e_fv));
      if (vt[v].e_fv) check("tbl_fch", 32'(first_ch), 32'(vt[v].e_fch));
    end
`ifdef LIVE_MON_MAXLAT_EN
    check("tbl_maxlat1", 32'(max_lat[15:8]), 32'd3);
`endif
    clr_err = 0;

    // ack stuck: 19 cycles harmless, 20 flags
    timeout = 0; req = 0;
    ack = 4'b0100; step(19);
    ack = 4'b0000; step(1);
    check("stuck19", 32'(err_stuck), 32'h0);
    ack = 4'b0100; step(19);
    check("stuck_pre20", 32'(err_stuck), 32'h0);
    step(1);
    check("stuck20", 32'(err_stuck), 32'h4);
    check("stuck_fch", 32'(first_ch), 32'd2);
    ack = 0; step(1);

    // timeout 0 disables starvation; enable drop restarts the wait
    timeout = 0; req = 4'b0001; step(300);
    check("to0_starve", 32'(err_starve), 32'h0);
    enable = 0; step(1);
    check("dis_stuck_kept", 32'(err_stuck), 32'h4);
    enable = 1; timeout = 10; step(9);
    check("reen_no_starve", 32'(err_starve), 32'h0);
    step(1);
    check("reen_starve", 32'(err_starve), 32'h1);

    // async reset mid-wait
    req = 4'b0011; timeout = 50; step(3);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_starve", 32'(err_starve), 32'h0);
    check("arst_stuck", 32'(err_stuck), 32'h0);
    check("arst_any", 32'(err_any), 32'h0);
    check("arst_fv", 32'(first_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    timeout = 2; req = 4'b0001; ack = 4'b0001; step(1);
    check("zero_lat_hs", 32'(err_starve), 32'h0);
    ack = 0; step(2);
    check("after_hs_starve", 32'(err_starve), 32'h1);

    // randomized traffic with occasional timeout changes, clears and disables
    clr_err = 1; step(1); clr_err = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NC; i++) begin
        if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
        if ($urandom_range(0, 7) == 0) ack[i] = ~ack[i];
      end
      if ($urandom_range(0, 40) == 0) timeout = 8'($urandom_range(0, 8));
      clr_err = ($urandom_range(0, 60) == 0);
      enable  = ($urandom_range(0, 80) != 0);
      step(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
